// File: rtl/counter_sched_if.sv
// Requester handshake and counter-control bundle for counter_sched.
// slave is the scheduler's view; master is the view of requesters plus the counter.
interface counter_sched_if #(
  parameter int COUNTER_WIDTH = 4,
  parameter int LEN_W         = 4
);
  logic                     req0;
  logic                     req1;
  logic                     dir0;
  logic                     dir1;
  logic [LEN_W-1:0]         len0;
  logic [LEN_W-1:0]         len1;
  logic                     gnt0;
  logic                     gnt1;
  logic                     done0;
  logic                     done1;
  logic                     cnt_act;
  logic                     cnt_up_dwn_n;
  logic                     cnt_ovflw;
  logic [COUNTER_WIDTH-1:0] cnt_count;

  modport slave (
    input  req0, req1, dir0, dir1, len0, len1, cnt_ovflw, cnt_count,
    output gnt0, gnt1, done0, done1, cnt_act, cnt_up_dwn_n
  );

  modport master (
    output req0, req1, dir0, dir1, len0, len1, cnt_ovflw, cnt_count,
    input  gnt0, gnt1, done0, done1, cnt_act, cnt_up_dwn_n
  );
endinterface

// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler that runs an up/down counter for a
// requested number of steps per job and locks into FAULT on counter overflow.
module counter_sched #(
  parameter int COUNTER_WIDTH = 4,
  parameter int LEN_W         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  counter_sched_if.slave  bus,
  output logic            busy,
  output logic            err
);

  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] RUN   = 5'b00010;
  localparam logic [4:0] DRAIN = 5'b00100;
  localparam logic [4:0] DONE  = 5'b01000;
  localparam logic [4:0] FAULT = 5'b10000;

  logic [4:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             win;
  logic             grant;

  // On a tie the requester that was not served last wins; rst_n gating keeps
  // grants silent while reset is held even if a request is pending.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      win = ~ptr_q;
    end else begin
      win = bus.req1;
    end
    grant = rst_n && (state_q == IDLE) && (bus.req0 || bus.req1) && !bus.cnt_ovflw;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    len_d   = len_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d = win;
          dir_d = win ? bus.dir1 : bus.dir0;
          len_d = win ? bus.len1 : bus.len0;
          if (len_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            rem_d   = len_d;
          end
        end
      end
      RUN: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    // Overflow overrides every other transition, including mid-job exits.
    if (bus.cnt_ovflw) begin
      state_d = FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      dir_q   <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  // ptr_q already points at the current job's owner once it leaves IDLE.
  assign bus.gnt0         = grant & ~win;
  assign bus.gnt1         = grant & win;
  assign bus.done0        = (state_q == DONE) & ~ptr_q;
  assign bus.done1        = (state_q == DONE) & ptr_q;
  assign bus.cnt_act      = (state_q == RUN);
  assign bus.cnt_up_dwn_n = (state_q != IDLE) & dir_q;
  assign busy             = (state_q != IDLE);
  assign err              = (state_q == FAULT);

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural up/down counter that
// wraps modulo 16 and sets a sticky overflow flag when it crosses the wrap.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       err;
  logic [3:0] cnt_q = 4'd0;
  logic       ovf_q = 1'b0;
  logic       cnt_load = 1'b0;
  logic [3:0] load_val = 4'd0;
  int         checks = 0;
  int         errors = 0;

  counter_sched_if #(.COUNTER_WIDTH(4), .LEN_W(4)) sif ();

  counter_sched #(.COUNTER_WIDTH(4), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  // External counter: one step per cycle with act high, sticky overflow on wrap.
  always @(posedge clk) begin
    if (cnt_load) begin
      cnt_q <= load_val;
      ovf_q <= 1'b0;
    end else if (sif.cnt_act) begin
      if (sif.cnt_up_dwn_n) begin
        if (cnt_q == 4'hF) ovf_q <= 1'b1;
        cnt_q <= cnt_q + 4'd1;
      end else begin
        if (cnt_q == 4'h0) ovf_q <= 1'b1;
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign sif.cnt_count = cnt_q;
  assign sif.cnt_ovflw = ovf_q;

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic load_count(input logic [3:0] v);
    cnt_load = 1'b1;
    load_val = v;
    next_cycle();
    cnt_load = 1'b0;
  endtask

  task automatic drop_reqs();
    sif.req0 = 1'b0;
    sif.req1 = 1'b0;
  endtask

  // Gathers per-cycle activity; sample index 1 is the first cycle after the grant edge.
  task automatic observe(input int n, output int act_cnt, output int d0_cnt, output int d0_idx,
                         output int d1_cnt, output int d1_idx, output int g_cnt);
    act_cnt = 0; d0_cnt = 0; d1_cnt = 0; d0_idx = -1; d1_idx = -1; g_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      if (sif.cnt_act) act_cnt++;
      if (sif.done0) begin d0_cnt++; if (d0_idx < 0) d0_idx = i; end
      if (sif.done1) begin d1_cnt++; if (d1_idx < 0) d1_idx = i; end
      if (sif.gnt0 || sif.gnt1) g_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    sif.req0 = 1'b1; sif.req1 = 1'b1;
    sif.dir0 = 1'b1; sif.dir1 = 1'b1;
    sif.len0 = 4'd0; sif.len1 = 4'd0;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (sif.gnt0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt0: got %b expected 0", sif.gnt0); end
    checks++; if (sif.gnt1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt1: got %b expected 0", sif.gnt1); end
    checks++; if ({sif.done0, sif.done1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done: got %b expected 00", {sif.done0, sif.done1}); end
    checks++; if (sif.cnt_act !== 1'b0) begin errors++; $display("[TB] FAIL reset_act: got %b expected 0", sif.cnt_act); end
    checks++; if (sif.cnt_up_dwn_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_updn: got %b expected 0", sif.cnt_up_dwn_n); end
    checks++; if ({busy, err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_err: got %b expected 00", {busy, err}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({sif.gnt0, sif.gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL first_tie: got %b expected 10", {sif.gnt0, sif.gnt1}); end
    next_cycle();
    drop_reqs();
    checks++; if ({sif.done0, sif.done1, busy} !== 3'b101) begin errors++; $display("[TB] FAIL tie_zero_len_done: got %b expected 101", {sif.done0, sif.done1, busy}); end
    next_cycle();
    checks++; if ({sif.done0, busy} !== 2'b00) begin errors++; $display("[TB] FAIL tie_back_idle: got %b expected 00", {sif.done0, busy}); end
  endtask

  task automatic test_up_job();
    int act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt;
    load_count(4'd0);
    sif.req0 = 1'b1; sif.dir0 = 1'b1; sif.len0 = 4'd3;
    #1;
    checks++; if ({sif.gnt0, sif.gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL up_gnt: got %b expected 10", {sif.gnt0, sif.gnt1}); end
    next_cycle();
    drop_reqs();
    checks++; if ({sif.cnt_act, sif.cnt_up_dwn_n, busy} !== 3'b111) begin errors++; $display("[TB] FAIL up_run_outputs: got %b expected 111", {sif.cnt_act, sif.cnt_up_dwn_n, busy}); end
    observe(8, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (act_cnt != 3) begin errors++; $display("[TB] FAIL up_act_cycles: got %0d expected 3", act_cnt); end
    checks++; if (d0_cnt != 1 || d0_idx != 5) begin errors++; $display("[TB] FAIL up_done0: got count %0d at %0d expected 1 at 5", d0_cnt, d0_idx); end
    checks++; if (d1_cnt != 0 || g_cnt != 0) begin errors++; $display("[TB] FAIL up_stray_pulses: got done1 %0d gnt %0d expected 0 0", d1_cnt, g_cnt); end
    checks++; if (cnt_q !== 4'd3) begin errors++; $display("[TB] FAIL up_count: got %0d expected 3", cnt_q); end
  endtask

  task automatic test_zero_len();
    int act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt;
    load_count(4'd5);
    sif.req1 = 1'b1; sif.dir1 = 1'b0; sif.len1 = 4'd0;
    #1;
    checks++; if ({sif.gnt0, sif.gnt1} !== 2'b01) begin errors++; $display("[TB] FAIL zero_gnt: got %b expected 01", {sif.gnt0, sif.gnt1}); end
    next_cycle();
    drop_reqs();
    observe(5, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (act_cnt != 0) begin errors++; $display("[TB] FAIL zero_act: got %0d expected 0", act_cnt); end
    checks++; if (d1_cnt != 1 || d1_idx != 1 || d0_cnt != 0) begin errors++; $display("[TB] FAIL zero_done1: got count %0d at %0d (done0 %0d) expected 1 at 1 (0)", d1_cnt, d1_idx, d0_cnt); end
    checks++; if (cnt_q !== 4'd5) begin errors++; $display("[TB] FAIL zero_count: got %0d expected 5", cnt_q); end
  endtask

  task automatic test_back_to_back();
    int order[4];
    int n_gnt = 0;
    int bad_order = 0;
    logic done_since = 1'b1;
    load_count(4'd0);
    sif.req0 = 1'b1; sif.dir0 = 1'b1; sif.len0 = 4'd2;
    sif.req1 = 1'b1; sif.dir1 = 1'b1; sif.len1 = 4'd2;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (sif.gnt0 || sif.gnt1) begin
        if (!done_since) bad_order++;
        if (n_gnt < 4) order[n_gnt] = sif.gnt1 ? 1 : 0;
        n_gnt++;
        done_since = 1'b0;
      end
      if (sif.done0 || sif.done1) done_since = 1'b1;
      @(posedge clk);
      #1;
    end
    drop_reqs();
    next_cycle();
    checks++; if (n_gnt != 4) begin errors++; $display("[TB] FAIL b2b_grants: got %0d expected 4", n_gnt); end
    checks++; if (n_gnt >= 4 && (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1)) begin errors++; $display("[TB] FAIL b2b_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]); end
    checks++; if (bad_order != 0) begin errors++; $display("[TB] FAIL b2b_done_first: got %0d violations expected 0", bad_order); end
    checks++; if (cnt_q !== 4'd8 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_count: got %0d busy %b expected 8 busy 0", cnt_q, busy); end
  endtask

  task automatic test_up_boundary();
    int act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt;
    load_count(4'd12);
    sif.req0 = 1'b1; sif.dir0 = 1'b1; sif.len0 = 4'd3;
    next_cycle();
    drop_reqs();
    observe(8, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (cnt_q !== 4'd15 || err !== 1'b0) begin errors++; $display("[TB] FAIL edge_up: got count %0d err %b expected 15 err 0", cnt_q, err); end
    checks++; if (d0_cnt != 1) begin errors++; $display("[TB] FAIL edge_done: got %0d expected 1", d0_cnt); end
  endtask

  task automatic test_reset_mid_job();
    int act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt;
    load_count(4'd0);
    sif.req0 = 1'b1; sif.dir0 = 1'b1; sif.len0 = 4'd8;
    next_cycle();
    drop_reqs();
    next_cycle();
    next_cycle();
    checks++; if (sif.cnt_act !== 1'b1) begin errors++; $display("[TB] FAIL mid_running: got act %b expected 1", sif.cnt_act); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({sif.cnt_act, sif.cnt_up_dwn_n, busy, err, sif.done0, sif.done1, sif.gnt0, sif.gnt1} !== 8'h00) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: got %b expected 00000000", {sif.cnt_act, sif.cnt_up_dwn_n, busy, err, sif.done0, sif.done1, sif.gnt0, sif.gnt1});
    end
    next_cycle();
    rst_n = 1'b1;
    observe(12, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (d0_cnt != 0 || act_cnt != 0) begin errors++; $display("[TB] FAIL mid_aborted: got done0 %0d act %0d expected 0 0", d0_cnt, act_cnt); end
    sif.req0 = 1'b1; sif.dir0 = 1'b1; sif.len0 = 4'd1;
    #1;
    checks++; if (sif.gnt0 !== 1'b1) begin errors++; $display("[TB] FAIL mid_regrant: got %b expected 1", sif.gnt0); end
    next_cycle();
    drop_reqs();
    observe(6, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (act_cnt != 1 || d0_cnt != 1 || d0_idx != 3) begin errors++; $display("[TB] FAIL mid_new_job: got act %0d done %0d at %0d expected 1 1 at 3", act_cnt, d0_cnt, d0_idx); end
  endtask

  task automatic test_fault();
    int act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt;
    load_count(4'd0);
    sif.req0 = 1'b1; sif.dir0 = 1'b0; sif.len0 = 4'd1;
    next_cycle();
    drop_reqs();
    observe(3, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if ({err, busy, sif.cnt_act} !== 3'b110) begin errors++; $display("[TB] FAIL fault_state: got err/busy/act %b expected 110", {err, busy, sif.cnt_act}); end
    checks++; if (d0_cnt != 0) begin errors++; $display("[TB] FAIL fault_no_done: got %0d expected 0", d0_cnt); end
    sif.req0 = 1'b1; sif.len0 = 4'd2; sif.req1 = 1'b1; sif.len1 = 4'd2;
    observe(10, act_cnt, d0_cnt, d0_idx, d1_cnt, d1_idx, g_cnt);
    checks++; if (g_cnt != 0 || act_cnt != 0 || d0_cnt != 0 || d1_cnt != 0) begin
      errors++; $display("[TB] FAIL fault_locked: got gnt %0d act %0d done %0d/%0d expected 0", g_cnt, act_cnt, d0_cnt, d1_cnt);
    end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky: got %b expected 1", err); end
    drop_reqs();
  endtask

  initial begin
    sif.req0 = 1'b0; sif.req1 = 1'b0;
    sif.dir0 = 1'b0; sif.dir1 = 1'b0;
    sif.len0 = 4'd0; sif.len1 = 4'd0;
    test_reset();
    test_up_job();
    test_zero_len();
    test_back_to_back();
    test_up_boundary();
    test_reset_mid_job();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
